// File: rtl/bridge_pkg.sv
// Shared constants for the ASCII command bridge: framing characters and
// decoder state encoding.
package bridge_pkg;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [3:0] READ_DIGITS  = 4'd4;
  localparam logic [3:0] WRITE_DIGITS = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic logic is_term(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/hex_to_nibble.sv
// Combinational ASCII hex digit decoder; nibble is 0 when is_hex is low.
module hex_to_nibble (
  input  logic [7:0] char,
  output logic [3:0] nibble,
  output logic       is_hex
);

  always_comb begin
    nibble = 4'd0;
    is_hex = 1'b0;
    if (char >= 8'h30 && char <= 8'h39) begin
      nibble = char[3:0];
      is_hex = 1'b1;
    end else if ((char >= 8'h41 && char <= 8'h46) ||
                 (char >= 8'h61 && char <= 8'h66)) begin
      // 'A'/'a' carry low nibble 1, so +9 lands on 10.
      nibble = char[3:0] + 4'd9;
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/bridge_rx.sv
// Decodes "R<4 hex><CR|LF>" and "W<8 hex><CR|LF>" byte streams from a UART
// receiver into single-cycle bus read/write requests.
module bridge_rx
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic [15:0] addr_o,
  output logic [15:0] data_o,
  output logic        rw_o,
  output logic        valid_o
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        rw_q, rw_d;
  logic        valid_q, valid_d;

  logic [3:0]  nibble;
  logic        is_hex;
  logic [3:0]  need;

  hex_to_nibble u_hex (
    .char   (data_i),
    .nibble (nibble),
    .is_hex (is_hex)
  );

  assign need = (state_q == WRITE) ? WRITE_DIGITS : READ_DIGITS;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    valid_d = 1'b0;
    if (valid_i) begin
      // A command letter restarts decoding from any state.
      if (data_i == ASCII_R) begin
        state_d = READ;
        cnt_d   = 4'd0;
        buf_d   = 32'd0;
      end else if (data_i == ASCII_W) begin
        state_d = WRITE;
        cnt_d   = 4'd0;
        buf_d   = 32'd0;
      end else if (state_q != IDLE) begin
        state_d = IDLE;
        if (is_hex) begin
          if (cnt_q != need) begin
            state_d = state_q;
            cnt_d   = cnt_q + 4'd1;
            buf_d   = {buf_q[27:0], nibble};
          end
        end else if (is_term(data_i) && (cnt_q == need)) begin
          valid_d = 1'b1;
          if (state_q == WRITE) begin
            addr_d = buf_q[31:16];
            data_d = buf_q[15:0];
            rw_d   = 1'b1;
          end else begin
            addr_d = buf_q[15:0];
            data_d = 16'd0;
            rw_d   = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      buf_q   <= 32'd0;
      addr_q  <= 16'd0;
      data_q  <= 16'd0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
    end
  end

  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign rw_o    = rw_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_bridge_rx.sv
// Scoreboarded bench for bridge_rx: a message-level model queues expected
// requests, and a negedge monitor checks every cycle of the DUT outputs.
module tb_bridge_rx;

  logic        clk;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [15:0] addr_o;
  logic [15:0] data_o;
  logic        rw_o;
  logic        valid_o;

  bridge_rx dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .addr_o  (addr_o),
    .data_o  (data_o),
    .rw_o    (rw_o),
    .valid_o (valid_o)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        rw;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;

  byte  mode = 0;
  int   digs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach its end (time %0t, required < 300000)", $time);
    $fatal(1);
  end

  function automatic int hexval(byte c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // Message-level model: collects digit values and converts on a terminator.
  task automatic model_byte(byte b, int at);
    int          need;
    int          hv;
    logic [31:0] v;
    exp_t        e;
    if (b == "R" || b == "W") begin
      mode = b;
      digs.delete();
    end else if (mode != 0) begin
      need = (mode == "W") ? 8 : 4;
      hv   = hexval(b);
      if (hv >= 0) begin
        if (digs.size() < need) digs.push_back(hv);
        else mode = 0;
      end else if (b == 8'h0D || b == 8'h0A) begin
        if (digs.size() == need) begin
          v = 0;
          foreach (digs[k]) v = v * 16 + digs[k];
          if (mode == "W") begin
            e.addr = v[31:16];
            e.data = v[15:0];
            e.rw   = 1'b1;
          end else begin
            e.addr = v[15:0];
            e.data = 16'd0;
            e.rw   = 1'b0;
          end
          e.cyc = at;
          exp_q.push_back(e);
        end
        mode = 0;
      end else begin
        mode = 0;
      end
    end
  endtask

  task automatic idle_cycles(int n);
    for (int k = 0; k < n; k++) begin
      data_i  = 8'($urandom);
      valid_i = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(byte b, int gap);
    data_i  = b;
    valid_i = 1'b1;
    model_byte(b, cyc + 1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    if (gap > 0) idle_cycles(gap);
  endtask

  task automatic send_str(string s, int max_gap);
    for (int k = 0; k < s.len(); k++)
      send_byte(s[k], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
  endtask

  task automatic pulse_reset(int n);
    #1;
    rst = 1'b1;
    mode = 0;
    digs.delete();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [15:0] last_addr = 16'd0;
  logic [15:0] last_data = 16'd0;
  logic        last_rw   = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_addr = 16'd0;
      last_data = 16'd0;
      last_rw   = 1'b0;
      vectors++;
      if (valid_o !== 1'b0 || addr_o !== 16'd0 || data_o !== 16'd0 || rw_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: valid=%b addr=%h data=%h rw=%b, required all zero",
                 valid_o, addr_o, data_o, rw_o);
      end
    end else if (valid_o === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: cyc=%0d addr=%h data=%h rw=%b, required no pulse",
                 cyc, addr_o, data_o, rw_o);
      end else begin
        e = exp_q.pop_front();
        if (addr_o !== e.addr || data_o !== e.data || rw_o !== e.rw || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL pulse: cyc=%0d addr=%h data=%h rw=%b, required cyc=%0d addr=%h data=%h rw=%b",
                   cyc, addr_o, data_o, rw_o, e.cyc, e.addr, e.data, e.rw);
        end else begin
          $display("pulse ok: cyc=%0d addr=%h data=%h rw=%b", cyc, addr_o, data_o, rw_o);
        end
        last_addr = e.addr;
        last_data = e.data;
        last_rw   = e.rw;
      end
    end else begin
      vectors++;
      if (valid_o !== 1'b0 || addr_o !== last_addr || data_o !== last_data || rw_o !== last_rw) begin
        miscompares++;
        $display("FAIL hold: cyc=%0d valid=%b addr=%h data=%h rw=%b, required valid=0 addr=%h data=%h rw=%b",
                 cyc, valid_o, addr_o, data_o, rw_o, last_addr, last_data, last_rw);
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        miscompares++;
        $display("FAIL missing_pulse: cyc=%0d, required pulse at cyc=%0d addr=%h",
                 cyc, exp_q[0].cyc, exp_q[0].addr);
        void'(exp_q.pop_front());
      end
    end
    if (done) begin
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL drain: %0d expected pulses outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  string hexch = "0123456789abcdefABCDEF";

  initial begin
    byte m;
    int  need, n, t;
    rst     = 1'b1;
    data_i  = 8'h00;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);

    send_str("R12aF\r\n", 0);
    idle_cycles(3);
    send_str("W00FFBEEF\n", 1);
    idle_cycles(3);
    send_str("R123\r", 1);
    send_str("R12345\r", 1);
    send_str("RG123\r", 1);
    idle_cycles(3);
    send_str("W12R0042\r", 0);
    idle_cycles(3);
    send_str("W1234", 0);
    idle_cycles(1);
    pulse_reset(2);
    send_str("5678\r", 0);
    send_str("R0001\r", 0);
    idle_cycles(3);
    send_str("R00A5\rW1234ABCD\n", 0);
    idle_cycles(3);

    for (int i = 0; i < 80; i++) begin
      m    = ($urandom_range(0, 1) == 0) ? "R" : "W";
      need = (m == "W") ? 8 : 4;
      n    = need;
      t    = $urandom_range(0, 9);
      if (t == 0) n = need - 1;
      else if (t == 1) n = need + 1;
      if ($urandom_range(0, 7) == 0) send_byte(8'($urandom), $urandom_range(0, 1));
      send_byte(m, $urandom_range(0, 2));
      for (int k = 0; k < n; k++) begin
        if (t == 2 && k == 1) send_byte("g", 0);
        send_byte(hexch[$urandom_range(0, hexch.len() - 1)], $urandom_range(0, 2));
      end
      case ($urandom_range(0, 2))
        0: send_byte(8'h0D, $urandom_range(0, 2));
        1: send_byte(8'h0A, $urandom_range(0, 2));
        default: begin
          send_byte(8'h0D, 0);
          send_byte(8'h0A, $urandom_range(0, 2));
        end
      endcase
    end

    idle_cycles(5);
    done = 1'b1;
  end

endmodule
